// File: rtl/layer_controller_ready_pio_pkg.sv
// Shared definitions for the neuron ready PIO: register map and edge-type codes.
package layer_controller_ready_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/layer_controller_ready_pio_if.sv
// Avalon-MM slave bus of the ready PIO.
//   address/chipselect/write_n/writedata : master -> slave
//   readdata (registered), irq (level)   : slave -> master
interface layer_controller_ready_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/layer_controller_ready_pio_sync_edge.sv
// One neuron ready lane: SYNC_STAGES-flop synchroniser plus edge detector.
//   clk, reset_n : clock, async active-low reset
//   d            : asynchronous ready line
//   edge_en      : qualifies det (low during warm-up)
//   synced       : synchronised level
//   det          : selected edge seen this cycle (rise/fall/any)
module layer_controller_sync_edge
  import layer_controller_ready_pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  input  logic edge_en,
  output logic synced,
  output logic det
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
    synced = sync_q[SYNC_STAGES-1];
    rise   = synced & ~prev_q;
    fall   = ~synced & prev_q;
    det    = 1'b0;
    if (EDGE_TYPE == EDGE_FALL)     det = fall;
    else if (EDGE_TYPE == EDGE_ANY) det = rise | fall;
    else                            det = rise;
    det = det & edge_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/layer_controller_ready_pio.sv
// Collects WIDTH neuron ready lines: per-lane sync + edge detect, sticky W1C
// edge capture, maskable level irq and an all-ready summary bit.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (addr0 data, addr1 status, addr2 irqmask, addr3 edgecapture)
//   in_port      : asynchronous ready lines
module layer_controller_ready_pio
  import layer_controller_ready_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  layer_controller_ready_pio_if.slave bus,
  input  logic [WIDTH-1:0]           in_port
);

  // Edges are qualified only once the synchroniser and prev flop hold real
  // samples, so lines already high at reset never register as edges.
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [2:0]       warm_cnt_q, warm_cnt_d;
  logic             edge_en;
  logic [WIDTH-1:0] synced, det;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      synced_ext, irqmask_ext, edgecap_ext;
  logic             wr_en;
  reg_addr_e        addr_e;

  assign edge_en = (warm_cnt_q == WARM_MAX);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    layer_controller_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (in_port[gi]),
      .edge_en(edge_en),
      .synced (synced[gi]),
      .det    (det[gi])
    );
  end

  always_comb begin
    addr_e      = reg_addr_e'(bus.address);
    wr_en       = bus.chipselect & ~bus.write_n;
    warm_cnt_d  = edge_en ? warm_cnt_q : warm_cnt_q + 3'd1;
    irqmask_d   = irqmask_q;
    clr         = '0;
    if (wr_en && addr_e == ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && addr_e == ADDR_EDGECAP) clr       = bus.writedata[WIDTH-1:0];
    // A new edge in the same cycle as its clear keeps the bit set.
    edgecap_d   = det | (edgecap_q & ~clr);

    synced_ext  = '0;
    irqmask_ext = '0;
    edgecap_ext = '0;
    synced_ext [WIDTH-1:0] = synced;
    irqmask_ext[WIDTH-1:0] = irqmask_q;
    edgecap_ext[WIDTH-1:0] = edgecap_q;

    readdata_d = '0;
    case (addr_e)
      ADDR_DATA:    readdata_d = synced_ext;
      ADDR_STATUS:  readdata_d = {30'd0, |edgecap_q, &synced};
      ADDR_IRQMASK: readdata_d = irqmask_ext;
      ADDR_EDGECAP: readdata_d = edgecap_ext;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt_q <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edgecap_q & irqmask_q);

endmodule
